// File: rtl/register_file.sv
// General-purpose register file: 2^ADDR_WIDTH entries, two combinational read
// ports (rs, rt) and one synchronous write port (rd). No write-through bypass.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [ADDR_WIDTH-1:0] rt,
  output logic [DATA_WIDTH-1:0] data_rs,
  output logic [DATA_WIDTH-1:0] data_rt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] registers [DEPTH];

  // Reset wins over a same-cycle write; register 0 is ordinary storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) registers[i] <= '0;
    end else if (en) begin
      registers[rd] <= data;
    end
  end

  assign data_rs = registers[rs];
  assign data_rt = registers[rt];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file with a shadow model of the array.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [4:0]  rd, rs, rt;
  logic [31:0] data, data_rs, data_rt;
  logic [31:0] model [32];
  int          compared = 0;
  int          mismatched = 0;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .en(en), .rd(rd), .data(data),
    .rs(rs), .rt(rt), .data_rs(data_rs), .data_rt(data_rt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a write on the falling edge, let it land on the rising edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    @(negedge clk);
    en = 1'b1; rd = a; data = v;
    @(posedge clk); #1;
    en = 1'b0;
    model[a] = v;
  endtask

  task automatic rd_both(input string tag, input logic [4:0] a, input logic [4:0] b);
    rs = a; rt = b; #1;
    check({tag, "_rs"}, data_rs, model[a]);
    check({tag, "_rt"}, data_rt, model[b]);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; rd = '0; rs = '0; rt = '0; data = '0;

    // Initial reset
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rd_both("reset_init", 5'd0, 5'd31);

    // Reset beats a same-cycle write
    for (int i = 0; i < 8; i++) wr(5'(i), 32'h0101_0101 * (i + 3));
    rd_both("preload", 5'd3, 5'd7);
    @(negedge clk);
    rst = 1'b1; en = 1'b1; rd = 5'd3; data = 32'h1234;
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int i = 0; i < 32; i++) begin
      rs = 5'(i); rt = 5'(i); #1;
      check("reset_clear_rs", data_rs, 32'h0);
      check("reset_clear_rt", data_rt, 32'h0);
    end

    // Sequential write / readback with hierarchical probe
    for (int i = 0; i < 8; i++) begin
      wr(5'(i), 32'h1111_1111 * (i + 1));
      check("probe", dut.registers[i], 32'h1111_1111 * (i + 1));
    end
    for (int i = 0; i < 8; i++) begin
      rs = 5'(i); #1;
      check("seq_rs", data_rs, 32'h1111_1111 * (i + 1));
    end
    for (int i = 0; i < 8; i++) begin
      rt = 5'(i); #1;
      check("seq_rt", data_rt, 32'h1111_1111 * (i + 1));
    end

    // Write enable low holds contents
    @(negedge clk);
    en = 1'b0; rd = 5'd5; data = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    rs = 5'd5; rt = 5'd5; #1;
    check("en_low_rs", data_rs, 32'h6666_6666);
    check("en_low_rt", data_rt, 32'h6666_6666);

    // Same-cycle write/read: old value before the edge, new value after
    wr(5'd4, 32'hA);
    @(negedge clk);
    en = 1'b1; rd = 5'd4; data = 32'hB; rs = 5'd4; rt = 5'd3;
    #1;
    check("hazard_old", data_rs, 32'hA);
    check("hazard_rt3", data_rt, 32'h4444_4444);
    @(posedge clk); #1;
    en = 1'b0; model[4] = 32'hB;
    rt = 5'd4; #1;
    check("hazard_new", data_rt, 32'hB);

    // Dual-port independence
    wr(5'd31, 32'hCAFE_F00D);
    wr(5'd0, 32'h0);
    rs = 5'd31; rt = 5'd31; #1;
    check("dual_same_rs", data_rs, 32'hCAFE_F00D);
    check("dual_same_rt", data_rt, 32'hCAFE_F00D);
    rs = 5'd0; rt = 5'd31; #1;
    check("dual_diff_rs", data_rs, 32'h0);
    check("dual_diff_rt", data_rt, 32'hCAFE_F00D);
    rs = 5'(0 - 1); #1;
    check("wrap_idx", data_rs, 32'hCAFE_F00D);

    // Register 0 is writable; full-range values; nothing else disturbed
    wr(5'd0, 32'hFFFF_FFFF);
    wr(5'd16, 32'h8000_0000);
    rs = 5'd0; rt = 5'd16; #1;
    check("r0_write", data_rs, 32'hFFFF_FFFF);
    check("r16_msb", data_rt, 32'h8000_0000);
    for (int i = 0; i < 32; i++) rd_both("final_sweep", 5'(i), 5'(31 - i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
